encoder_16_bit_seq: RTL and testbench

- Sequential 16-to-4 encoder; the return path for the team's 4-to-16 one-hot decoder.
- Accepts a 16-bit request vector with any number of bits set.
- Emits the 4-bit index of each set bit, one per output handshake, in a fixed priority order.
- Sits between request/flag sources and any consumer that needs binary indices, e.g. interrupt or grant servicing.

---
 rtl/encoder_16_bit_seq.sv | 109 ++++++++++
 tb/tb_encoder_16_bit_seq.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/encoder_16_bit_seq.sv
// Sequential N-to-WIDTH encoder: loads a request vector and emits the index of
// each set bit, one per o_valid/o_ready handshake, lowest-first or highest-first.
module encoder_16_bit_seq #(
  parameter int WIDTH     = 4,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2**WIDTH-1:0]   i,
  input  logic                  i_valid,
  output logic                  i_ready,
  output logic [WIDTH-1:0]      o,
  output logic                  o_valid,
  input  logic                  o_ready,
  output logic                  o_last,
  output logic [WIDTH:0]        cnt,
  output logic                  none
);
  localparam int N = 2**WIDTH;

  typedef enum logic {IDLE, EMIT} state_t;

  state_t           state_q, state_d;
  logic [N-1:0]     pending_q, pending_d;
  logic [WIDTH:0]   cnt_q, cnt_d;
  logic             none_q, none_d;

  logic [WIDTH-1:0] idx;
  logic [N-1:0]     sel;
  logic             last;

  function automatic logic [WIDTH:0] popcnt(input logic [N-1:0] v);
    logic [WIDTH:0] s;
    s = '0;
    for (int k = 0; k < N; k++) s = s + {{WIDTH{1'b0}}, v[k]};
    return s;
  endfunction

  // Priority pick over the registered pending set; the last match in scan order wins.
  always_comb begin
    idx = '0;
    if (LSB_FIRST) begin
      for (int k = N-1; k >= 0; k--) if (pending_q[k]) idx = WIDTH'(k);
    end else begin
      for (int k = 0; k < N; k++) if (pending_q[k]) idx = WIDTH'(k);
    end
  end

  // One-hot of the bit being emitted, and "exactly one bit left" detect.
  always_comb begin
    sel      = '0;
    sel[idx] = 1'b1;
    last     = (pending_q != '0) && ((pending_q & (pending_q - N'(1))) == '0);
  end

  // Next-state: load in IDLE, retire one bit per handshake in EMIT.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    cnt_d     = cnt_q;
    none_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          if (i != '0) begin
            pending_d = i;
            cnt_d     = popcnt(i);
            state_d   = EMIT;
          end else begin
            cnt_d  = '0;
            none_d = 1'b1;
          end
        end
      end
      EMIT: begin
        if (o_ready) begin
          pending_d = pending_q & ~sel;
          if (last) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset that aborts any vector in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      cnt_q     <= '0;
      none_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      none_q    <= none_d;
    end
  end

  // Outputs depend only on registered state so they hold steady under stall.
  always_comb begin
    i_ready = (state_q == IDLE);
    o_valid = (state_q == EMIT);
    o       = o_valid ? idx : '0;
    o_last  = o_valid && last;
    cnt     = cnt_q;
    none    = none_q;
  end
endmodule

// File: tb/tb_encoder_16_bit_seq.sv
// Bench: two instances (lowest-first and highest-first) share stimulus; each
// loaded vector is expanded into an ordered index list and compared per cycle.
module tb_encoder_16_bit_seq;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] i;
  logic        i_valid, o_ready;
  logic        ir_a, ov_a, ol_a, nn_a;
  logic        ir_b, ov_b, ol_b, nn_b;
  logic [3:0]  o_a, o_b;
  logic [4:0]  cnt_a, cnt_b;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  encoder_16_bit_seq #(.WIDTH(4), .LSB_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst), .i(i), .i_valid(i_valid), .i_ready(ir_a),
    .o(o_a), .o_valid(ov_a), .o_ready(o_ready), .o_last(ol_a),
    .cnt(cnt_a), .none(nn_a));

  encoder_16_bit_seq #(.WIDTH(4), .LSB_FIRST(1'b0)) dut_m (
    .clk(clk), .rst(rst), .i(i), .i_valid(i_valid), .i_ready(ir_b),
    .o(o_b), .o_valid(ov_b), .o_ready(o_ready), .o_last(ol_b),
    .cnt(cnt_b), .none(nn_b));

  typedef struct {
    logic [15:0] vec;
    int          ecnt;
    int          efirst_lsb;
    int          efirst_msb;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d want %0d", nm, act, exp);
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, ".i_ready"}, ir_a & ir_b, 1);
    chk({nm, ".o_valid"}, ov_a | ov_b, 0);
  endtask

  // Apply one vector and follow it to the end of EMIT.
  task automatic run_vec(input logic [15:0] vec, input int hold0, input int stall_pct,
                         input bit inj, input bit use_exp, input vec_t r);
    int qa[$];
    int qb[$];
    int k, pos, guard, cyc;
    bit rdy;
    for (int b = 0; b < 16; b++) if (vec[b]) qa.push_back(b);
    for (int b = 15; b >= 0; b--) if (vec[b]) qb.push_back(b);
    k = qa.size();
    @(negedge clk);
    chk_idle("pre_load");
    i = vec; i_valid = 1'b1; o_ready = ($urandom_range(1) == 1);
    @(negedge clk);
    i_valid = inj; i = 16'hFFFF;
    if (k == 0) begin
      chk("zero.none", nn_a & nn_b, 1);
      chk("zero.cnt", cnt_a + cnt_b, 0);
      chk_idle("zero");
      i_valid = 1'b0;
      @(negedge clk);
      chk("zero.none_drop", nn_a | nn_b, 0);
      return;
    end
    chk("load.none", nn_a | nn_b, 0);
    if (use_exp) begin
      chk("tbl.cnt", cnt_a, r.ecnt);
      chk("tbl.first_lsb", o_a, r.efirst_lsb);
      chk("tbl.first_msb", o_b, r.efirst_msb);
    end
    pos = 0; guard = 0; cyc = 0;
    while (pos < k && guard < 2000) begin
      chk("emit.o_valid", ov_a & ov_b, 1);
      chk("emit.i_ready", ir_a | ir_b, 0);
      chk("emit.o_lsb", o_a, qa[pos]);
      chk("emit.o_msb", o_b, qb[pos]);
      chk("emit.o_last", ol_a + ol_b, (pos == k-1) ? 2 : 0);
      chk("emit.cnt", cnt_a + cnt_b, 2*k);
      rdy = (cyc >= hold0) && ($urandom_range(99) >= stall_pct);
      o_ready = rdy;
      if (inj) i = 16'($urandom);
      @(negedge clk);
      if (rdy) pos++;
      cyc++; guard++;
    end
    if (guard >= 2000) chk("emit.timeout", 1, 0);
    i_valid = 1'b0;
    o_ready = ($urandom_range(1) == 1);
    chk_idle("post");
    chk("post.cnt_hold", cnt_a + cnt_b, 2*k);
  endtask

  vec_t tbl[8];
  vec_t nr;

  initial begin
    tbl[0] = '{16'h0000,  0,  0,  0};
    tbl[1] = '{16'h8421,  4,  0, 15};
    tbl[2] = '{16'h0081,  2,  0,  7};
    tbl[3] = '{16'h0006,  2,  1,  2};
    tbl[4] = '{16'hFFFF, 16,  0, 15};
    tbl[5] = '{16'h0F00,  4,  8, 11};
    tbl[6] = '{16'h0001,  1,  0,  0};
    tbl[7] = '{16'h8000,  1, 15, 15};
    nr     = '{16'h0000, 0, 0, 0};

    rst = 1'b1; i = 16'h1234; i_valid = 1'b1; o_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_idle("reset");
    chk("reset.o", o_a + o_b, 0);
    chk("reset.o_last", ol_a | ol_b, 0);
    chk("reset.cnt", cnt_a + cnt_b, 0);
    chk("reset.none", nn_a | nn_b, 0);
    rst = 1'b0; i_valid = 1'b0;

    // Table vectors at full o_ready.
    for (int t = 0; t < 8; t++) run_vec(tbl[t].vec, 0, 0, 1'b0, 1'b1, tbl[t]);

    // Five stall cycles on the first index, with a load attempt during EMIT.
    run_vec(16'h0006, 5, 0, 1'b1, 1'b1, tbl[3]);

    // Reset after the second handshake of 0F00 discards the rest.
    @(negedge clk);
    i = 16'h0F00; i_valid = 1'b1; o_ready = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
    chk("rst_mid.o0", o_a, 8);
    @(negedge clk);
    chk("rst_mid.o1", o_a, 9);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_idle("rst_mid");
    chk("rst_mid.cnt", cnt_a + cnt_b, 0);
    repeat (3) begin
      @(negedge clk);
      chk("rst_mid.quiet", ov_a | ov_b, 0);
    end

    // Randomized vectors with random stalls and load attempts during EMIT.
    for (int n = 0; n < 150; n++) begin
      logic [15:0] v;
      case ($urandom_range(3))
        0: v = 16'($urandom) & 16'($urandom) & 16'($urandom);
        1: v = (n % 10 == 0) ? 16'h0000 : 16'($urandom);
        default: v = 16'($urandom) & 16'($urandom);
      endcase
      run_vec(v, $urandom_range(2), $urandom_range(50), 1'($urandom_range(1)), 1'b0, nr);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
